// File: rtl/mxu_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mxu_accumulator
// Purpose  : Sums acc_len consecutive 64-bit smul products per signed SIMD
//            lane (8x8b / 4x16b / 2x32b / 1x64b). Each finished group is
//            presented with per-lane sticky overflow flags on a valid/ready
//            output. In FP mode a product passes through with no
//            accumulation.
// Ports    : clk, aresetn (async, active-low), sclr (sync clear), ce (enable)
//            in_valid/in_ready/res_mac_next : product stream in
//            select_precision, enable_fp_unit, acc_len : group config,
//                                             latched on a group's first beat
//            out_valid/out_ready/out_data/out_ovf : result stream out
//            busy : state machine is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mxu_accumulator #(
  parameter int SATURATE  = 1,
  parameter int ACC_LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 sclr,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          res_mac_next,
  input  logic [3:0]           select_precision,
  input  logic [1:0]           enable_fp_unit,
  input  logic [ACC_LEN_W-1:0] acc_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [7:0]           out_ovf,
  output logic                 busy
);

  // Precision codes, matching the values in precision_def.vh.
  localparam logic [3:0] PREC_INT8  = 4'd0;
  localparam logic [3:0] PREC_INT16 = 4'd1;
  localparam logic [3:0] PREC_INT32 = 4'd2;

  localparam logic [ACC_LEN_W-1:0] LEN_ONE = {{(ACC_LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           prec_q, prec_d;     // 0:8b 1:16b 2:32b 3:64b lanes
  logic [ACC_LEN_W-1:0] len_q, len_d;
  logic [ACC_LEN_W-1:0] count_q, count_d;
  logic [63:0]          acc_q, acc_d;
  logic [7:0]           ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                 beat;
  logic [1:0]           new_prec;
  logic [ACC_LEN_W-1:0] new_len;
  logic [ACC_LEN_W-1:0] count_inc;

  // Per-lane add results for each of the four lane widths; the group's
  // latched precision selects one set.
  logic [3:0][63:0]     lane_sum;
  logic [3:0][7:0]      lane_ovf;

  for (genvar k = 0; k < 4; k++) begin : g_width
    localparam int W = 8 << k;
    localparam int N = 8 >> k;
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         o;
      assign a = acc_q[i*W +: W];
      assign b = res_mac_next[i*W +: W];
      assign s = a + b;
      // Signed overflow: operands agree in sign but the sum does not.
      assign o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      // On overflow the clamp direction follows the operands' common sign.
      assign lane_sum[k][i*W +: W] = (o && (SATURATE != 0)) ?
                                     {a[W-1], {(W-1){~a[W-1]}}} : s;
      assign lane_ovf[k][i] = o;
    end
    if (N < 8) begin : g_pad
      assign lane_ovf[k][7:N] = '0;
    end
  end

  assign in_ready = ce & ((state_q != ST_HOLD) | out_ready);

  // Config decode for a group that starts on this beat.
  always_comb begin
    unique case (select_precision)
      PREC_INT8:  new_prec = 2'd0;
      PREC_INT16: new_prec = 2'd1;
      PREC_INT32: new_prec = 2'd2;
      default:    new_prec = 2'd3;
    endcase
    if ((|enable_fp_unit) || (acc_len == '0)) begin
      new_len = LEN_ONE;
    end else begin
      new_len = acc_len;
    end
  end

  assign count_inc = count_q + LEN_ONE;

  always_comb begin
    state_d   = state_q;
    prec_d    = prec_q;
    len_d     = len_q;
    count_d   = count_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    beat      = in_valid & in_ready;
    if (sclr) begin
      state_d = ST_IDLE;
      prec_d  = 2'd0;
      len_d   = '0;
      count_d = '0;
      acc_d   = '0;
      ovf_d   = '0;
    end else if (ce) begin
      case (state_q)
        ST_ACCUM: begin
          if (beat) begin
            acc_d   = lane_sum[prec_q];
            ovf_d   = ovf_q | lane_ovf[prec_q];
            count_d = count_inc;
            if (count_inc == len_q) begin
              state_d = ST_HOLD;
            end
          end
        end
        default: begin
          // IDLE, or HOLD with the result being taken: a beat here opens a
          // new group in the same cycle so a HOLD->HOLD stream has no bubble.
          if (beat) begin
            acc_d   = res_mac_next;
            ovf_d   = '0;
            count_d = LEN_ONE;
            prec_d  = new_prec;
            len_d   = new_len;
            state_d = (new_len == LEN_ONE) ? ST_HOLD : ST_ACCUM;
          end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      prec_q      <= 2'd0;
      len_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prec_q      <= prec_d;
      len_q       <= len_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
